// File: rtl/mem_stage_ctrl.sv
// Y86-64 memory-stage controller: decodes an execute record into one data-memory
// access, captures the response and presents a held write-back record; owns processor halt.
module mem_stage_ctrl #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_icode,
   input  logic [2:0]  req_stat,
   input  logic [63:0] req_valE,
   input  logic [63:0] req_valA,
   input  logic [63:0] req_valP,
   input  logic [3:0]  req_dstE,
   input  logic [3:0]  req_dstM,
   output logic [63:0] mem_addr,
   output logic        mem_wen,
   output logic [63:0] mem_wdata,
   output logic        mem_ren,
   input  logic [63:0] mem_rdata,
   input  logic        mem_err,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [3:0]  wb_icode,
   output logic [63:0] wb_valE,
   output logic [63:0] wb_valM,
   output logic [3:0]  wb_dstE,
   output logic [3:0]  wb_dstM,
   output logic [2:0]  wb_stat
);

   localparam logic [2:0] AOK = 3'd1;
   localparam logic [2:0] HLT = 3'd2;
   localparam logic [2:0] ADR = 3'd3;
   localparam logic [2:0] INS = 3'd4;

   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state, state_next;
   logic        halted;
   logic        op_rd, op_wr;
   logic        dec_rd, dec_wr, dec_bad, dec_go;
   logic [63:0] dec_addr, dec_wdata;
   logic        fire;

   // Access decode of the incoming record.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      dec_rd    = 1'b0;
      dec_wr    = 1'b0;
      dec_addr  = req_valE;
      dec_wdata = req_valA;
      case (req_icode)
         I_RMMOVQ, I_PUSHQ: dec_wr = 1'b1;
         I_CALL: begin
            dec_wr    = 1'b1;
            dec_wdata = req_valP;
         end
         I_MRMOVQ: dec_rd = 1'b1;
         I_RET, I_POPQ: begin
            dec_rd   = 1'b1;
            dec_addr = req_valA;
         end
         default: ;
      endcase
   end

   assign dec_bad = (dec_rd | dec_wr) && (dec_addr >= 64'(MEM_WORDS));
   assign dec_go  = (dec_rd | dec_wr) && (req_stat == AOK) && !dec_bad;
   assign fire    = req_valid & req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Accept is computed from req_valid/halted directly so state_next never loops through req_ready.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      mem_wen    = 1'b0;
      mem_ren    = 1'b0;
      wb_valid   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !halted;
            if (req_valid && !halted) state_next = dec_go ? ISSUE : RESP;
         end
         ISSUE: begin
            mem_wen    = op_wr;
            mem_ren    = op_rd;
            state_next = WAIT;
         end
         WAIT: state_next = RESP;
         RESP: begin
            wb_valid = 1'b1;
            if (wb_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: non-blocking assignments only here, so every register samples pre-edge values.
         op_rd     <= 1'b0;
         op_wr     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wb_icode  <= '0;
         wb_valE   <= '0;
         wb_valM   <= '0;
         wb_dstE   <= REG_NONE;
         wb_dstM   <= REG_NONE;
         wb_stat   <= AOK;
         halted    <= 1'b0;
      end else begin
         if (fire) begin
            op_rd    <= dec_rd & dec_go;
            op_wr    <= dec_wr & dec_go;
            wb_icode <= req_icode;
            wb_valE  <= req_valE;
            wb_valM  <= '0;
            if (dec_go) begin
               mem_addr  <= dec_addr;
               mem_wdata <= dec_wdata;
            end
            if (req_stat != AOK) begin
               wb_stat <= req_stat;
               wb_dstE <= req_dstE;
               wb_dstM <= req_dstM;
            end else if (dec_bad) begin
               wb_stat <= ADR;
               wb_dstE <= REG_NONE;
               wb_dstM <= REG_NONE;
            end else begin
               wb_stat <= AOK;
               wb_dstE <= req_dstE;
               wb_dstM <= req_dstM;
            end
         end else if (state == WAIT) begin
            if (op_rd) wb_valM <= mem_rdata;
            // A memory error can only arrive on an AOK record, so ADR overrides cleanly.
            if (mem_err) begin
               wb_stat <= ADR;
               wb_dstE <= REG_NONE;
               wb_dstM <= REG_NONE;
            end
         end
         if (wb_valid && wb_ready && (wb_stat != AOK)) halted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed vector table, reset-abort sequence,
// and randomized records checked against a rule-level reference model with its own memory.
module tb_mem_stage_ctrl;

   localparam int MEM_WORDS = 1024;
   localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
   localparam logic [3:0] F = 4'hF;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [3:0]  req_icode, req_dstE, req_dstM;
   logic [2:0]  req_stat;
   logic [63:0] req_valE, req_valA, req_valP;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_wen, mem_ren, mem_err;
   logic        wb_valid, wb_ready;
   logic [3:0]  wb_icode, wb_dstE, wb_dstM;
   logic [63:0] wb_valE, wb_valM;
   logic [2:0]  wb_stat;

   mem_stage_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_icode(req_icode),
      .req_stat(req_stat), .req_valE(req_valE), .req_valA(req_valA), .req_valP(req_valP),
      .req_dstE(req_dstE), .req_dstM(req_dstM),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_ren(mem_ren),
      .mem_rdata(mem_rdata), .mem_err(mem_err),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_icode(wb_icode), .wb_valE(wb_valE),
      .wb_valM(wb_valM), .wb_dstE(wb_dstE), .wb_dstM(wb_dstM), .wb_stat(wb_stat)
   );

   always #5 clk = ~clk;

   // Data memory seen by the DUT: read data and error valid the cycle after the strobe edge.
   logic [63:0] dmem [MEM_WORDS];
   bit          err_inject;
   bit          mem_clear;

   always @(posedge clk) begin
      mem_rdata <= '0;
      mem_err   <= 1'b0;
      if (mem_clear) foreach (dmem[i]) dmem[i] <= '0;
      if (mem_wen || mem_ren) mem_err <= err_inject;
      if (mem_wen && !err_inject && mem_addr < 64'(MEM_WORDS)) dmem[mem_addr[9:0]] <= mem_wdata;
      if (mem_ren && mem_addr < 64'(MEM_WORDS)) mem_rdata <= dmem[mem_addr[9:0]];
   end

   typedef struct {
      logic [3:0]  icode;
      logic [2:0]  stat;
      logic [63:0] valE, valA, valP;
      logic [3:0]  dstE, dstM;
      bit          err;
      int          stall;
      int          lat;
      bit          wr, rd;
      logic [63:0] addr, wdata, valM;
      logic [2:0]  wstat;
      logic [3:0]  wdstE, wdstM;
   } vec_t;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [3:0] icode, input logic [2:0] stat,
                               input logic [63:0] valE, input logic [63:0] valA,
                               input logic [63:0] valP, input logic [3:0] dstE,
                               input logic [3:0] dstM, input bit err, input int stall,
                               input int lat, input bit wr, input bit rd,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] valM, input logic [2:0] wstat,
                               input logic [3:0] wdstE, input logic [3:0] wdstM);
      vec_t v;
      v.icode = icode; v.stat = stat; v.valE = valE; v.valA = valA; v.valP = valP;
      v.dstE = dstE; v.dstM = dstM; v.err = err; v.stall = stall; v.lat = lat;
      v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.valM = valM;
      v.wstat = wstat; v.wdstE = wdstE; v.wdstM = wdstM;
      return v;
   endfunction

   // Reference memory, updated only by the model.
   logic [63:0] ref_mem [MEM_WORDS];

   task automatic model(inout vec_t v);
      bit is_rd, is_wr, bad, go;
      logic [63:0] a;
      is_wr = (v.icode == 4'h4) || (v.icode == 4'h8) || (v.icode == 4'hA);
      is_rd = (v.icode == 4'h5) || (v.icode == 4'h9) || (v.icode == 4'hB);
      a     = ((v.icode == 4'h9) || (v.icode == 4'hB)) ? v.valA : v.valE;
      bad   = (is_rd || is_wr) && (a >= 64'(MEM_WORDS));
      go    = (is_rd || is_wr) && (v.stat == AOK) && !bad;
      v.lat   = go ? 3 : 1;
      v.wr    = go && is_wr;
      v.rd    = go && is_rd;
      v.addr  = a;
      v.wdata = (v.icode == 4'h8) ? v.valP : v.valA;
      v.valM  = (go && is_rd) ? ref_mem[a[9:0]] : 64'h0;
      if (go && is_wr && !v.err) ref_mem[a[9:0]] = v.wdata;
      if (v.stat != AOK)             v.wstat = v.stat;
      else if (bad || (go && v.err)) v.wstat = ADR;
      else                           v.wstat = AOK;
      v.wdstE = (v.wstat == ADR && v.stat == AOK) ? F : v.dstE;
      v.wdstM = (v.wstat == ADR && v.stat == AOK) ? F : v.dstM;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " req_ready"}, req_ready, 1);
      check({tag, " wb_valid"}, wb_valid, 0);
      check({tag, " strobes"}, {mem_wen, mem_ren}, 0);
      check({tag, " mem_addr"}, mem_addr, 0);
      check({tag, " mem_wdata"}, mem_wdata, 0);
      check({tag, " wb_vals"}, wb_valE | wb_valM, 0);
      check({tag, " wb_meta"}, {wb_icode, wb_stat, wb_dstE, wb_dstM}, {4'h0, AOK, F, F});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge.
   task automatic run_txn(input vec_t t, input string tag);
      int n, wr_cnt, rd_cnt, spurious;
      logic [63:0] s_addr, s_wdata;
      check({tag, " ready_before"}, req_ready, 1);
      err_inject = t.err;
      req_icode = t.icode; req_stat = t.stat; req_valE = t.valE; req_valA = t.valA;
      req_valP = t.valP; req_dstE = t.dstE; req_dstM = t.dstM; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n = 1; wr_cnt = 0; rd_cnt = 0; s_addr = '0; s_wdata = '0;
      while (!wb_valid && n < 10) begin
         if (mem_wen) begin wr_cnt++; s_addr = mem_addr; s_wdata = mem_wdata; end
         if (mem_ren) begin rd_cnt++; s_addr = mem_addr; end
         @(negedge clk);
         n++;
      end
      check({tag, " wb_valid"}, wb_valid, 1);
      check({tag, " latency"}, 64'(n), 64'(t.lat));
      check({tag, " wr_strobes"}, 64'(wr_cnt), 64'(t.wr));
      check({tag, " rd_strobes"}, 64'(rd_cnt), 64'(t.rd));
      if (t.wr || t.rd) check({tag, " mem_addr"}, s_addr, t.addr);
      if (t.wr) check({tag, " mem_wdata"}, s_wdata, t.wdata);
      for (int c = 0; c <= t.stall; c++) begin
         check({tag, " wb_valE"}, wb_valE, t.valE);
         check({tag, " wb_valM"}, wb_valM, t.valM);
         check({tag, " wb_meta"}, {wb_icode, wb_stat, wb_dstE, wb_dstM},
               {t.icode, t.wstat, t.wdstE, t.wdstM});
         check({tag, " resp_hold"}, {wb_valid, req_ready, mem_wen, mem_ren}, 4'b1000);
         if (c < t.stall) @(negedge clk);
      end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      err_inject = 1'b0;
      check({tag, " wb_done"}, wb_valid, 0);
      if (t.wstat == AOK) begin
         check({tag, " ready_after"}, req_ready, 1);
      end else begin
         check({tag, " halted_ready"}, req_ready, 0);
         req_icode = 4'h5; req_stat = AOK; req_valE = 64'd5; req_valid = 1'b1;
         spurious = 0;
         repeat (3) begin
            @(negedge clk);
            if (mem_wen || mem_ren || wb_valid || req_ready) spurious++;
         end
         req_valid = 1'b0;
         check({tag, " halted_ignores"}, 64'(spurious), 0);
         do_reset();
      end
   endtask

   function automatic logic [63:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 8)  return 64'(600 + $urandom_range(0, 15));
      if (r == 8) return 64'(MEM_WORDS + $urandom_range(0, 5000));
      return {1'b1, 63'($urandom)};
   endfunction

   vec_t tbl [18];
   vec_t rv;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; mem_clear = 1'b1; err_inject = 1'b0;
      req_valid = 1'b0; wb_ready = 1'b0;
      req_icode = '0; req_stat = AOK; req_valE = '0; req_valA = '0; req_valP = '0;
      req_dstE = F; req_dstM = F;
      foreach (ref_mem[i]) ref_mem[i] = '0;
      repeat (2) @(negedge clk);
      mem_clear = 1'b0;
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      //          icode stat valE      valA   valP  dE dM err stl  lat wr rd addr  wdata  valM   wstat wdE wdM
      tbl[0]  = mk(4'h4, AOK, 101,      3025,  7,    F, F, 0, 5,   3, 1, 0, 101,  3025,  0,     AOK, F, F);
      tbl[1]  = mk(4'h5, AOK, 101,      0,     9,    F, 2, 0, 0,   3, 0, 1, 101,  0,     3025,  AOK, F, 2);
      tbl[2]  = mk(4'h5, AOK, 201,      0,     9,    F, 4, 0, 1,   3, 0, 1, 201,  0,     0,     AOK, F, 4);
      tbl[3]  = mk(4'hA, AOK, 401,      4576,  11,   4, F, 0, 0,   3, 1, 0, 401,  4576,  0,     AOK, 4, F);
      tbl[4]  = mk(4'hB, AOK, 409,      401,   13,   4, 3, 0, 0,   3, 0, 1, 401,  0,     4576,  AOK, 4, 3);
      tbl[5]  = mk(4'h8, AOK, 392,      1,     'h55, 4, F, 0, 0,   3, 1, 0, 392,  'h55,  0,     AOK, 4, F);
      tbl[6]  = mk(4'h9, AOK, 400,      392,   20,   4, F, 0, 0,   3, 0, 1, 392,  0,     'h55,  AOK, 4, F);
      tbl[7]  = mk(4'h6, AOK, 77,       5,     22,   2, F, 0, 2,   1, 0, 0, 0,    0,     0,     AOK, 2, F);
      tbl[8]  = mk(4'h5, AOK, 1023,     0,     24,   F, 1, 0, 0,   3, 0, 1, 1023, 0,     0,     AOK, F, 1);
      tbl[9]  = mk(4'h3, AOK, 9,        0,     42,   1, F, 0, 0,   1, 0, 0, 0,    0,     0,     AOK, 1, F);
      tbl[10] = mk(4'h5, AOK, 101,      0,     26,   F, 3, 1, 0,   3, 0, 1, 101,  0,     3025,  ADR, F, F);
      tbl[11] = mk(4'h5, AOK, 2905,     0,     28,   F, 5, 0, 0,   1, 0, 0, 0,    0,     0,     ADR, F, F);
      tbl[12] = mk(4'h4, AOK, 1024,     9,     30,   F, F, 0, 0,   1, 0, 0, 0,    0,     0,     ADR, F, F);
      tbl[13] = mk(4'h5, AOK, 64'h8000_0000_0000_0005, 0, 32, F, 6, 0, 0, 1, 0, 0, 0, 0, 0, ADR, F, F);
      tbl[14] = mk(4'h4, AOK, 50,       99,    34,   7, 7, 1, 0,   3, 1, 0, 50,   99,    0,     ADR, F, F);
      tbl[15] = mk(4'h0, HLT, 0,        0,     36,   F, F, 0, 0,   1, 0, 0, 0,    0,     0,     HLT, F, F);
      tbl[16] = mk(4'h5, INS, 5,        0,     38,   F, 6, 0, 0,   1, 0, 0, 0,    0,     0,     INS, F, 6);
      tbl[17] = mk(4'hB, AOK, 0,        1024,  40,   4, 3, 0, 0,   1, 0, 0, 0,    0,     0,     ADR, F, F);
      foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

      // Reset while a write is on the bus: everything returns to reset values at once
      // and the write never reaches memory.
      req_icode = 4'h4; req_stat = AOK; req_valE = 64'd300; req_valA = 64'hABC;
      req_dstE = F; req_dstM = F; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("abort issue_wen", mem_wen, 1);
      #2 rst = 1'b1;
      #1 check_reset_vals("abort");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_txn(mk(4'h5, AOK, 300, 0, 2, F, 2, 0, 0, 3, 0, 1, 300, 0, 0, AOK, F, 2), "after_abort");

      for (int i = 0; i < 40; i++) begin
         rv.icode = 4'($urandom_range(0, 11));
         case ($urandom_range(0, 19))
            0:       rv.stat = HLT;
            1:       rv.stat = INS;
            2:       rv.stat = ADR;
            default: rv.stat = AOK;
         endcase
         rv.valE  = pick_addr();
         rv.valA  = ((rv.icode == 4'h9) || (rv.icode == 4'hB)) ? pick_addr() : {$urandom, $urandom};
         rv.valP  = {$urandom, $urandom};
         rv.dstE  = 4'($urandom);
         rv.dstM  = 4'($urandom);
         rv.err   = ($urandom_range(0, 9) == 0);
         rv.stall = $urandom_range(0, 2);
         model(rv);
         run_txn(rv, $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
